// File: rtl/dc_motor_setpoint_ramp.sv
// Signed setpoint to cw/ccw + 12-bit magnitude for the DC motor H-bridge driver.
// Slew-limits the magnitude and forces ramp-to-zero plus a dead gap on every reversal.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | disabled or just reset; outputs off, magnitude held at 0
//  S_RUN   | ramping toward the target magnitude in the current direction
//  S_BRAKE | reversal requested; ramping to 0 with the old direction kept
//  S_DEAD  | bridge fully off for DEAD_TIME clocks before the new direction
module dc_motor_setpoint_ramp #(
    parameter int unsigned MAX_VALUE = 4095,
    parameter int unsigned RAMP_STEP = 1,
    parameter int unsigned RAMP_DIV  = 100,
    parameter int unsigned DEAD_TIME = 50
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [14:0] i_value_in,
    output logic        o_cw_out,
    output logic        o_ccw_out,
    output logic [11:0] o_value_out,
    output logic        o_at_target
);

    localparam logic [15:0] C_MAX_WIDE  = 16'(MAX_VALUE);
    localparam logic [11:0] C_MAX       = 12'(MAX_VALUE);
    localparam logic [12:0] C_STEP      = 13'(RAMP_STEP);
    localparam logic [15:0] C_DIV_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [15:0] C_DEAD_LOAD = 16'(DEAD_TIME - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BRAKE = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t      r_state;
    logic [11:0] r_mag;
    logic        r_dir;          // 0 = cw, 1 = ccw (same sense as the setpoint sign bit)
    logic [15:0] r_presc;
    logic [15:0] r_dead_cnt;
    logic        r_tgt_sign;
    logic [11:0] r_tgt_mag;

    state_t      w_state_nxt;
    logic [11:0] w_mag_nxt;
    logic        w_dir_nxt;
    logic [15:0] w_presc_nxt;
    logic [15:0] w_dead_nxt;
    logic        w_tick;
    logic        w_reversal;
    logic [15:0] w_abs_in;
    logic [11:0] w_tgt_mag_in;
    logic        w_drive;
    logic        w_at_target;
    logic [11:0] w_value;

    // One slew step toward tgt; snaps onto tgt when within one step so it never overshoots.
    function automatic logic [11:0] f_ramp(input logic [11:0] cur, input logic [11:0] tgt);
        logic [12:0] diff;
        logic [12:0] moved;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
        end
        if (diff <= C_STEP) begin
            moved = {1'b0, tgt};
        end else if (tgt > cur) begin
            moved = {1'b0, cur} + C_STEP;
        end else begin
            moved = {1'b0, cur} - C_STEP;
        end
        return moved[11:0];
    endfunction

    // -16384 negates to 16384, which falls into the saturation branch.
    always_comb begin
        w_abs_in = i_value_in[14] ? (16'd0 - {i_value_in[14], i_value_in})
                                  : {1'b0, i_value_in};
        w_tgt_mag_in = (w_abs_in > C_MAX_WIDE) ? C_MAX : w_abs_in[11:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_dir_nxt   = r_dir;
        w_dead_nxt  = r_dead_cnt;
        w_tick      = i_enable && (r_presc == C_DIV_LAST);
        w_reversal  = (r_tgt_mag != 12'd0) && (r_tgt_sign != r_dir);
        if (!i_enable) begin
            w_presc_nxt = 16'd0;
        end else if (w_tick) begin
            w_presc_nxt = 16'd0;
        end else begin
            w_presc_nxt = r_presc + 16'd1;
        end

        if (!i_enable) begin
            w_state_nxt = S_IDLE;
            w_mag_nxt   = 12'd0;
            w_dead_nxt  = 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_RUN;
                    if (r_tgt_mag != 12'd0) begin
                        w_dir_nxt = r_tgt_sign;
                    end
                end
                S_RUN: begin
                    if (w_reversal) begin
                        if (r_mag != 12'd0) begin
                            w_state_nxt = S_BRAKE;
                        end else begin
                            w_state_nxt = S_DEAD;
                            w_dead_nxt  = C_DEAD_LOAD;
                        end
                    end else if (w_tick) begin
                        w_mag_nxt = f_ramp(r_mag, r_tgt_mag);
                    end
                end
                S_BRAKE: begin
                    if (!w_reversal) begin
                        w_state_nxt = S_RUN;
                    end else if (w_tick) begin
                        w_mag_nxt = f_ramp(r_mag, 12'd0);
                        if (w_mag_nxt == 12'd0) begin
                            w_state_nxt = S_DEAD;
                            w_dead_nxt  = C_DEAD_LOAD;
                        end
                    end
                end
                S_DEAD: begin
                    if (r_dead_cnt == 16'd0) begin
                        w_state_nxt = S_RUN;
                        if (r_tgt_mag != 12'd0) begin
                            w_dir_nxt = r_tgt_sign;
                        end
                    end else begin
                        w_dead_nxt = r_dead_cnt - 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_mag_nxt   = 12'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values so the registered copies line up with the state.
    always_comb begin
        w_drive = ((w_state_nxt == S_RUN) || (w_state_nxt == S_BRAKE)) &&
                  ((w_mag_nxt != 12'd0) || ((w_state_nxt == S_RUN) && (w_tgt_mag_in != 12'd0)));
        w_at_target = (w_state_nxt == S_RUN) && (w_mag_nxt == w_tgt_mag_in) &&
                      ((w_tgt_mag_in == 12'd0) || (w_dir_nxt == i_value_in[14]));
        w_value = ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DEAD)) ? 12'd0 : w_mag_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_mag       <= 12'd0;
            r_dir       <= 1'b0;
            r_presc     <= 16'd0;
            r_dead_cnt  <= 16'd0;
            r_tgt_sign  <= 1'b0;
            r_tgt_mag   <= 12'd0;
            o_cw_out    <= 1'b0;
            o_ccw_out   <= 1'b0;
            o_value_out <= 12'd0;
            o_at_target <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mag       <= w_mag_nxt;
            r_dir       <= w_dir_nxt;
            r_presc     <= w_presc_nxt;
            r_dead_cnt  <= w_dead_nxt;
            r_tgt_sign  <= i_value_in[14];
            r_tgt_mag   <= w_tgt_mag_in;
            o_cw_out    <= w_drive && !w_dir_nxt;
            o_ccw_out   <= w_drive && w_dir_nxt;
            o_value_out <= w_value;
            o_at_target <= w_at_target;
        end
    end

endmodule

// File: tb/tb_dc_motor_setpoint_ramp.sv
// Bench for dc_motor_setpoint_ramp: directed vector table, hand corner sequences,
// and random setpoints checked every clock against a behavioural model.
module tb_dc_motor_setpoint_ramp;

    localparam int STEP = 10;
    localparam int DIV  = 4;
    localparam int DEAD = 8;
    localparam int MAXV = 4095;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_BRAKE = 2;
    localparam int P_DEAD  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [14:0] vin;
    logic        cw_out;
    logic        ccw_out;
    logic [11:0] value_out;
    logic        at_target;

    always #5 clk = ~clk;

    dc_motor_setpoint_ramp #(
        .MAX_VALUE(MAXV),
        .RAMP_STEP(STEP),
        .RAMP_DIV (DIV),
        .DEAD_TIME(DEAD)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_enable   (en),
        .i_value_in (vin),
        .o_cw_out   (cw_out),
        .o_ccw_out  (ccw_out),
        .o_value_out(value_out),
        .o_at_target(at_target)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model: signed target, direction +1/-1, magnitude, phase, remaining dead clocks
    int m_phase, m_tgt, m_dir, m_mag, m_dead_left, m_en_cycles;
    int e_cw, e_ccw, e_val, e_at;
    int prev_val;

    typedef struct {
        bit en;
        int vin;
        int n;
        bit cw;
        bit ccw;
        int val;
        bit at;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int isgn(input int x);
        return (x < 0) ? -1 : 1;
    endfunction

    function automatic int sat_of(input logic [14:0] v);
        int s;
        s = int'($signed(v));
        if (s > MAXV) s = MAXV;
        if (s < -MAXV) s = -MAXV;
        return s;
    endfunction

    function automatic int approach(input int cur, input int tgt);
        if (iabs(tgt - cur) <= STEP) return tgt;
        return (tgt > cur) ? cur + STEP : cur - STEP;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_tgt = 0; m_dir = 1; m_mag = 0;
        m_dead_left = 0; m_en_cycles = 0;
        e_cw = 0; e_ccw = 0; e_val = 0; e_at = 0;
        prev_val = 0;
    endtask

    task automatic model_step(input bit e, input logic [14:0] v);
        bit tick;
        int tm;
        int live;
        int push;
        tick = e && ((m_en_cycles % DIV) == DIV - 1);
        m_en_cycles = e ? m_en_cycles + 1 : 0;
        tm = iabs(m_tgt);
        if (!e) begin
            m_phase = P_IDLE;
            m_mag = 0;
        end else if (m_phase == P_IDLE) begin
            m_phase = P_RUN;
            if (tm != 0) m_dir = isgn(m_tgt);
        end else if (m_phase == P_RUN) begin
            if (tm != 0 && isgn(m_tgt) != m_dir) begin
                if (m_mag != 0) m_phase = P_BRAKE;
                else begin m_phase = P_DEAD; m_dead_left = DEAD; end
            end else if (tick) begin
                m_mag = approach(m_mag, tm);
            end
        end else if (m_phase == P_BRAKE) begin
            if (tm == 0 || isgn(m_tgt) == m_dir) m_phase = P_RUN;
            else if (tick) begin
                m_mag = approach(m_mag, 0);
                if (m_mag == 0) begin m_phase = P_DEAD; m_dead_left = DEAD; end
            end
        end else begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_phase = P_RUN;
                if (tm != 0) m_dir = isgn(m_tgt);
            end
        end
        m_tgt = sat_of(v);
        tm = iabs(m_tgt);
        live = (m_phase == P_RUN || m_phase == P_BRAKE) ? 1 : 0;
        push = (live != 0 && (m_mag != 0 || (m_phase == P_RUN && tm != 0))) ? 1 : 0;
        e_cw  = (push != 0 && m_dir > 0) ? 1 : 0;
        e_ccw = (push != 0 && m_dir < 0) ? 1 : 0;
        e_val = (m_phase == P_IDLE || m_phase == P_DEAD) ? 0 : m_mag;
        e_at  = (m_phase == P_RUN && m_mag == tm && (tm == 0 || isgn(m_tgt) == m_dir)) ? 1 : 0;
    endtask

    task automatic do_clk(input bit e, input int v);
        int d;
        en  = e;
        vin = 15'(v);
        @(posedge clk);
        model_step(e, 15'(v));
        #1;
        chk("cw_model",  cw_out,    e_cw);
        chk("ccw_model", ccw_out,   e_ccw);
        chk("val_model", value_out, e_val);
        chk("at_model",  at_target, e_at);
        chk("cw_ccw_exclusive", cw_out & ccw_out, 0);
        if (e) begin
            d = int'(value_out) - prev_val;
            chk("slew_limit", (d > STEP || d < -STEP) ? 1 : 0, 0);
        end
        prev_val = int'(value_out);
    endtask

    task automatic chk_outs(input string name, input bit cw, input bit ccw, input int val, input bit at);
        chk({name, "_cw"},  cw_out,    cw);
        chk({name, "_ccw"}, ccw_out,   ccw);
        chk({name, "_val"}, value_out, val);
        chk({name, "_at"},  at_target, at);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; vin = 15'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        chk_outs(name, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        en = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vin = 15'd0;
        model_reset();

        tbl.push_back('{1'b1,    100,    1, 1'b1, 1'b0,    0, 1'b0});
        tbl.push_back('{1'b1,    100,    3, 1'b1, 1'b0,   10, 1'b0});
        tbl.push_back('{1'b1,    100,   36, 1'b1, 1'b0,  100, 1'b1});
        tbl.push_back('{1'b1,   -150,    1, 1'b1, 1'b0,  100, 1'b0});
        tbl.push_back('{1'b1,   -150,   38, 1'b1, 1'b0,   10, 1'b0});
        tbl.push_back('{1'b1,   -150,    1, 1'b0, 1'b0,    0, 1'b0});
        tbl.push_back('{1'b1,   -150,    7, 1'b0, 1'b0,    0, 1'b0});
        tbl.push_back('{1'b1,   -150,    1, 1'b0, 1'b1,    0, 1'b0});
        tbl.push_back('{1'b1,   -150,    4, 1'b0, 1'b1,   10, 1'b0});
        tbl.push_back('{1'b1,   -150,   56, 1'b0, 1'b1,  150, 1'b1});
        tbl.push_back('{1'b1,  16383,    1, 1'b0, 1'b1,  150, 1'b0});
        tbl.push_back('{1'b1,  16383,   59, 1'b0, 1'b0,    0, 1'b0});
        tbl.push_back('{1'b1,  16383,    8, 1'b1, 1'b0,    0, 1'b0});
        tbl.push_back('{1'b1,  16383, 1640, 1'b1, 1'b0, 4095, 1'b1});
        tbl.push_back('{1'b1, -16384,    1, 1'b1, 1'b0, 4095, 1'b0});
        tbl.push_back('{1'b1, -16384, 1639, 1'b0, 1'b0,    0, 1'b0});
        tbl.push_back('{1'b1, -16384,    8, 1'b0, 1'b1,    0, 1'b0});
        tbl.push_back('{1'b1, -16384, 1640, 1'b0, 1'b1, 4095, 1'b1});
        tbl.push_back('{1'b1,      0,    1, 1'b0, 1'b1, 4095, 1'b0});
        tbl.push_back('{1'b1,      0, 1639, 1'b0, 1'b0,    0, 1'b1});

        // Directed table: ramp up, reversal with dead gap, saturation, ramp to zero
        do_reset();
        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++) do_clk(tbl[k].en, tbl[k].vin);
            chk_outs($sformatf("vec%0d", k), tbl[k].cw, tbl[k].ccw, tbl[k].val, tbl[k].at);
        end

        // Brake aborted by a same-direction setpoint: back to RUN with no dead gap
        do_reset();
        for (int c = 0; c < 40; c++) do_clk(1'b1, 100);
        for (int c = 0; c < 16; c++) do_clk(1'b1, -50);
        chk_outs("brake_at60", 1, 0, 60, 0);
        for (int c = 0; c < 8; c++) begin
            do_clk(1'b1, 80);
            chk("abort_no_gap_cw", cw_out, 1);
        end
        chk_outs("abort_at80", 1, 0, 80, 1);

        // Enable dropped mid-ramp, re-enabled with a negative setpoint
        do_reset();
        for (int c = 0; c < 6; c++) do_clk(1'b1, 100);
        chk_outs("pre_disable", 1, 0, 10, 0);
        do_clk(1'b0, -40);
        chk_outs("disabled", 0, 0, 0, 0);
        do_clk(1'b1, -40);
        chk_outs("reenable", 0, 1, 0, 0);
        for (int c = 0; c < 3; c++) do_clk(1'b1, -40);
        chk_outs("reenable_tick", 0, 1, 10, 0);

        // Reset pulse while braking
        do_reset();
        for (int c = 0; c < 40; c++) do_clk(1'b1, 100);
        for (int c = 0; c < 5; c++) do_clk(1'b1, -150);
        chk_outs("in_brake", 1, 0, 90, 0);
        async_reset("rst_brake");
        do_clk(1'b0, 30);
        do_clk(1'b0, 30);
        chk_outs("post_rst_idle", 0, 0, 0, 0);
        do_clk(1'b1, 30);
        chk_outs("post_rst_run", 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) do_clk(1'b1, 30);
        chk_outs("post_rst_tick", 1, 0, 10, 0);

        // Reset pulse while in the dead gap
        do_reset();
        for (int c = 0; c < 8; c++) do_clk(1'b1, 20);
        for (int c = 0; c < 10; c++) do_clk(1'b1, -20);
        chk_outs("in_dead", 0, 0, 0, 0);
        async_reset("rst_dead");
        do_clk(1'b0, 20);
        do_clk(1'b1, 20);
        chk_outs("post_dead_rst", 1, 0, 0, 0);

        // Random setpoints against the model
        do_reset();
        for (int s = 0; s < 70; s++) begin
            int r;
            int v;
            int len;
            bit e;
            e = ($urandom_range(0, 9) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 6) v = int'($urandom_range(0, 400)) - 200;
            else if (r < 8) v = 0;
            else v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(3000, 16383))
                                                 : -int'($urandom_range(3000, 16384));
            len = int'($urandom_range(1, 70));
            if ($urandom_range(0, 19) == 0) do_reset();
            for (int c = 0; c < len; c++) do_clk(e, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
